// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send/ready sequencer feeding a UART transmit controller.
// Issues one-cycle send pulses, paced on the controller's ready, with a sticky busy timeout.
module uart_tx_feeder #(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  tx_ready,
  output logic                  tx_send,
  output logic [7:0]            tx_data,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  idle,
  output logic [15:0]           sent_count,
  output logic                  err_timeout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [DEPTH_LOG2:0] DEPTH_VAL   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [TW-1:0]       TIMEOUT_VAL = TW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  full_reg;
  logic [TW-1:0]         wait_cnt_reg, wait_cnt_next;
  logic                  err_reg, err_next;
  logic                  tx_send_reg;
  logic [7:0]            tx_data_reg;
  logic [15:0]           sent_reg;
  logic                  push, pop;

  // in_ready comes from the registered full flag, so a push can never land on a full FIFO.
  assign in_ready    = !full_reg;
  assign push        = in_valid && !full_reg;
  assign tx_send     = tx_send_reg;
  assign tx_data     = tx_data_reg;
  assign fifo_count  = count_reg;
  assign sent_count  = sent_reg;
  assign err_timeout = err_reg;
  assign idle        = (count_reg == '0) && (state_reg == S_IDLE) && tx_ready;

  always_comb begin
    state_next    = state_reg;
    pop           = 1'b0;
    wait_cnt_next = wait_cnt_reg;
    err_next      = err_reg;
    case (state_reg)
      S_IDLE: begin
        wait_cnt_next = '0;
        if ((count_reg != '0) && tx_ready) begin
          pop        = 1'b1;
          state_next = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!tx_ready) begin
          wait_cnt_next = '0;
          state_next    = S_WAIT_DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
          if (wait_cnt_next == TIMEOUT_VAL) begin
            err_next   = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
      tx_send_reg  <= 1'b0;
      tx_data_reg  <= 8'h00;
      sent_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      full_reg     <= (count_next == DEPTH_VAL);
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
      tx_send_reg  <= pop;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        tx_data_reg <= mem[rd_ptr_reg];
        sent_reg    <= sent_reg + 1'b1;
      end
    end
  end

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

endmodule
